// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl - bit-serial sequencer wrapped around a 1-bit ALU slice.
// Captures two WIDTH-bit operands plus opsel/mode/carry-in on start.
// Feeds the slice one bit pair per cycle, LSB first.
// Collects the result bits and the final carry.
// Optional feature macro: ALU_SERIAL_ZERO_FLAG_EN (registered result==0 flag).
module alu_serial_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       opsel_in,
   input  logic             mode_in,
   input  logic             cin_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             zero,
   output logic             slice_op1,
   output logic             slice_op2,
   output logic             slice_cin,
   output logic [2:0]       slice_opsel,
   output logic             slice_mode,
   input  logic             slice_result,
   input  logic             slice_cout
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_opsel;
   logic             r_mode;
   logic             r_carry;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-2:0] r_res_sh;
   logic [WIDTH-1:0] r_result;
   logic             r_cout;
   logic             w_start_acc;
   logic             w_last;
   logic [WIDTH-1:0] w_assembled;

   assign w_start_acc = (r_state == S_IDLE) && start;
   assign w_last      = (r_state == S_SHIFT) && (r_count == CNT_W'(WIDTH - 1));
   // The current slice bit enters at the MSB; earlier bits have already
   // moved down, so on the final edge bit i lines up with operand bit i.
   assign w_assembled = {slice_result, r_res_sh};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic: start is only looked at in IDLE, DONE always returns
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_next = S_SHIFT;
         S_SHIFT: if (w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Output decode: slice bit lanes are forced low outside SHIFT
   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      slice_op1 = 1'b0;
      slice_op2 = 1'b0;
      slice_cin = 1'b0;
      unique case (r_state)
         S_SHIFT: begin
            busy      = 1'b1;
            slice_op1 = r_a[0];
            slice_op2 = r_b[0];
            slice_cin = r_carry;
         end
         S_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // Operand/carry/count capture on start, then shift once per SHIFT edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_opsel  <= '0;
         r_mode   <= 1'b0;
         r_carry  <= 1'b0;
         r_count  <= '0;
         r_res_sh <= '0;
      end else if (w_start_acc) begin
         r_a      <= a;
         r_b      <= b;
         r_opsel  <= opsel_in;
         r_mode   <= mode_in;
         r_carry  <= cin_in;
         r_count  <= '0;
         r_res_sh <= '0;
      end else if (r_state == S_SHIFT) begin
         r_a      <= r_a >> 1;
         r_b      <= r_b >> 1;
         r_carry  <= slice_cout;
         r_count  <= r_count + CNT_W'(1);
         r_res_sh <= w_assembled[WIDTH-1:1];
      end
   end

   // Visible result/carry change only on the final SHIFT edge, so they
   // stay stable from DONE until the next operation completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result <= '0;
         r_cout   <= 1'b0;
      end else if (w_last) begin
         r_result <= w_assembled;
         r_cout   <= slice_cout;
      end
   end

   assign result      = r_result;
   assign cout        = r_cout;
   assign slice_opsel = r_opsel;
   assign slice_mode  = r_mode;

`ifdef ALU_SERIAL_ZERO_FLAG_EN
   logic r_zero;

   // Zero flag follows the result; an accepted start clears it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           r_zero <= 1'b0;
      else if (w_start_acc) r_zero <= 1'b0;
      else if (w_last)      r_zero <= (w_assembled == '0);
   end

   assign zero = r_zero;
`else
   assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed testbench for alu_serial_ctrl (WIDTH=8) with a behavioural slice:
// mode 0 = full adder, mode 1 = AND.
module tb_alu_serial_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [2:0]   opsel_in;
   logic         mode_in;
   logic         cin_in;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         zero;
   logic         slice_op1;
   logic         slice_op2;
   logic         slice_cin;
   logic [2:0]   slice_opsel;
   logic         slice_mode;
   logic         slice_result;
   logic         slice_cout;

   int n_chk  = 0;
   int n_fail = 0;

   alu_serial_ctrl #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .a            (a),
      .b            (b),
      .opsel_in     (opsel_in),
      .mode_in      (mode_in),
      .cin_in       (cin_in),
      .busy         (busy),
      .done         (done),
      .result       (result),
      .cout         (cout),
      .zero         (zero),
      .slice_op1    (slice_op1),
      .slice_op2    (slice_op2),
      .slice_cin    (slice_cin),
      .slice_opsel  (slice_opsel),
      .slice_mode   (slice_mode),
      .slice_result (slice_result),
      .slice_cout   (slice_cout)
   );

   // Behavioural 1-bit slice
   always_comb begin
      if (slice_mode) begin
         slice_result = slice_op1 & slice_op2;
         slice_cout   = 1'b0;
      end else begin
         slice_result = slice_op1 ^ slice_op2 ^ slice_cin;
         slice_cout   = (slice_op1 & slice_op2) | (slice_op1 & slice_cin) | (slice_op2 & slice_cin);
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one operation; caller must be 1 time unit after a rising edge.
   // inj >= 0 drives a second start (a=0x11) during SHIFT bit inj.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic [2:0] op, input logic m, input logic c,
                         input logic [W-1:0] exp_r, input logic exp_c,
                         input logic exp_z, input int inj);
      logic carry;
      logic ez;
      a = ta; b = tb_v; opsel_in = op; mode_in = m; cin_in = c; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = ~ta; b = ~tb_v; opsel_in = ~op; mode_in = ~m; cin_in = ~c;
      carry = c;
      for (int i = 0; i < W; i++) begin
         if (i == inj) begin
            start = 1'b1;
            a     = 8'h11;
         end else begin
            start = 1'b0;
         end
         chk("shift_busy", busy, 1);
         chk("shift_done", done, 0);
         chk("slice_op1", slice_op1, ta[i]);
         chk("slice_op2", slice_op2, tb_v[i]);
         chk("slice_cin", slice_cin, carry);
         chk("slice_opsel", slice_opsel, op);
         chk("slice_mode", slice_mode, m);
         carry = m ? 1'b0 : ((ta[i] & tb_v[i]) | (ta[i] & carry) | (tb_v[i] & carry));
         @(posedge clk); #1;
      end
      start = 1'b0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      ez = exp_z;
`else
      ez = 1'b0;
`endif
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 1);
      chk("result", result, exp_r);
      chk("cout", cout, exp_c);
      chk("zero", zero, ez);
      chk("done_op1", slice_op1, 0);
      @(posedge clk); #1;
      chk("done_end", done, 0);
      chk("idle_busy", busy, 0);
      chk("result_hold", result, exp_r);
      chk("cout_hold", cout, exp_c);
      @(posedge clk); #1;
      chk("no_requeue", busy, 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      opsel_in = '0; mode_in = 1'b0; cin_in = 1'b0;

      // Reset held for 3 cycles
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_cout", cout, 0);
      chk("rst_zero", zero, 0);
      chk("rst_slice", {slice_op1, slice_op2, slice_cin, slice_opsel, slice_mode}, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("idle_busy20", busy, 0);
         chk("idle_done20", done, 0);
      end

      // Add: 0x5A + 0x3C = 0x96
      run_op(8'h5A, 8'h3C, 3'b000, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0, -1);
      // Carry out with zero result
      run_op(8'hFF, 8'h01, 3'b001, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, -1);
      // Carry-in used for bit 0: 1 + 1 + 1 = 3
      run_op(8'h01, 8'h01, 3'b000, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, -1);
      // Logic AND through the slice
      run_op(8'hF0, 8'hCC, 3'b010, 1'b1, 1'b0, 8'hC0, 1'b0, 1'b0, -1);
      // Second start during SHIFT bit 3 is ignored: 0x0F + 0x01 = 0x10
      run_op(8'h0F, 8'h01, 3'b000, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 3);

      // Reset during SHIFT bit 4 aborts the operation
      a = 8'h77; b = 8'h22; opsel_in = 3'b101; mode_in = 1'b0; cin_in = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("pre_abort_busy", busy, 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_result", result, 0);
      chk("abort_cout", cout, 0);
      chk("abort_zero", zero, 0);
      chk("abort_slice", {slice_op1, slice_op2, slice_cin, slice_opsel, slice_mode}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("abort_idle", busy, 0);
      // Fresh operation after abort: 0x12 + 0x34 = 0x46
      run_op(8'h12, 8'h34, 3'b000, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
